// File: rtl/jesd204_rx_ilas_check.sv
// rtl/jesd204_rx_ilas_check.sv - JESD204 per-lane ILAS tracker, checker and config extractor
module jesd204_rx_ilas_check #(
  parameter int NUM_MULTIFRAMES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cgs_ready,
  input  logic [7:0]  cfg_beats_per_multiframe,
  input  logic [31:0] data,
  input  logic [3:0]  charisk,
  input  logic [3:0]  char_is_error,
  output logic        ilas_config_valid,
  output logic [1:0]  ilas_config_addr,
  output logic [31:0] ilas_config_data,
  output logic        ilas_done,
  output logic        ilas_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_R,
    S_ILAS,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [7:0] CHAR_R  = 8'h1C;
  localparam logic [7:0] CHAR_Q  = 8'h9C;
  localparam logic [7:0] CHAR_A  = 8'h7C;
  localparam logic [2:0] LAST_MF = 3'(NUM_MULTIFRAMES - 1);

  state_t      state, state_next;
  logic [7:0]  beat_cnt, beat_next;
  logic [2:0]  mf_cnt, mf_next;
  logic        cfg_valid_next;
  logic [1:0]  cfg_addr_next;
  logic [31:0] cfg_data_next;

  logic octet0_is_r, octet1_is_q, octet3_is_a;
  logic first_beat, last_beat, config_beat, check_fail;
  logic unused_charisk;

  assign octet0_is_r    = charisk[0] && (data[7:0]   == CHAR_R);
  assign octet1_is_q    = charisk[1] && (data[15:8]  == CHAR_Q);
  assign octet3_is_a    = charisk[3] && (data[31:24] == CHAR_A);
  assign unused_charisk = charisk[2];

  assign first_beat  = (beat_cnt == 8'd0);
  assign last_beat   = (beat_cnt == cfg_beats_per_multiframe);
  assign config_beat = (mf_cnt == 3'd1) && (beat_cnt < 8'd4);
  assign check_fail  = (first_beat && !octet0_is_r) ||
                       (last_beat && !octet3_is_a) ||
                       ((mf_cnt == 3'd1) && first_beat && !octet1_is_q) ||
                       (|char_is_error);

  always_comb begin
    state_next     = state;
    beat_next      = beat_cnt;
    mf_next        = mf_cnt;
    cfg_valid_next = 1'b0;
    cfg_addr_next  = ilas_config_addr;
    cfg_data_next  = ilas_config_data;
    case (state)
      S_IDLE: begin
        beat_next  = 8'd0;
        mf_next    = 3'd0;
        state_next = S_WAIT_R;
      end
      S_WAIT_R: begin
        // The qualifying /R/ beat is beat 0 of multiframe 0, so the count resumes at 1.
        if (octet0_is_r) begin
          if (|char_is_error) begin
            state_next = S_ERROR;
          end else begin
            state_next = S_ILAS;
            beat_next  = 8'd1;
            mf_next    = 3'd0;
          end
        end
      end
      S_ILAS: begin
        if (config_beat) begin
          cfg_valid_next = 1'b1;
          cfg_addr_next  = beat_cnt[1:0];
          cfg_data_next  = data;
        end
        if (check_fail) begin
          state_next = S_ERROR;
        end else if (last_beat) begin
          beat_next = 8'd0;
          if (mf_cnt == LAST_MF) state_next = S_DONE;
          else                   mf_next    = mf_cnt + 3'd1;
        end else begin
          beat_next = beat_cnt + 8'd1;
        end
      end
      S_DONE:  state_next = S_DONE;
      S_ERROR: state_next = S_ERROR;
      default: state_next = S_IDLE;
    endcase
    if (!cgs_ready) begin
      state_next     = S_IDLE;
      beat_next      = 8'd0;
      mf_next        = 3'd0;
      cfg_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= S_IDLE;
      beat_cnt          <= 8'd0;
      mf_cnt            <= 3'd0;
      ilas_config_valid <= 1'b0;
      ilas_config_addr  <= 2'd0;
      ilas_config_data  <= 32'd0;
    end else begin
      state             <= state_next;
      beat_cnt          <= beat_next;
      mf_cnt            <= mf_next;
      ilas_config_valid <= cfg_valid_next;
      ilas_config_addr  <= cfg_addr_next;
      ilas_config_data  <= cfg_data_next;
    end
  end

  assign ilas_done  = (state == S_DONE);
  assign ilas_error = (state == S_ERROR);

endmodule

// File: tb/tb_jesd204_rx_ilas_check.sv
// tb/tb_jesd204_rx_ilas_check.sv - self-checking bench for jesd204_rx_ilas_check
module tb_jesd204_rx_ilas_check;

  localparam int NUM_MF = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cgs_ready;
  logic [7:0]  cfg_bpm;
  logic [31:0] data;
  logic [3:0]  charisk;
  logic [3:0]  char_is_error;
  logic        ilas_config_valid;
  logic [1:0]  ilas_config_addr;
  logic [31:0] ilas_config_data;
  logic        ilas_done;
  logic        ilas_error;

  int n_vec  = 0;
  int n_miss = 0;

  logic [33:0] exp_q[$];
  logic [31:0] cfg_words[4] = '{32'h0201_9C1C, 32'h0605_0403, 32'h0A09_0807, 32'h0E0D_0C0B};

  always #5 clk = ~clk;

  jesd204_rx_ilas_check #(.NUM_MULTIFRAMES(NUM_MF)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .cgs_ready                (cgs_ready),
    .cfg_beats_per_multiframe (cfg_bpm),
    .data                     (data),
    .charisk                  (charisk),
    .char_is_error            (char_is_error),
    .ilas_config_valid        (ilas_config_valid),
    .ilas_config_addr         (ilas_config_addr),
    .ilas_config_data         (ilas_config_data),
    .ilas_done                (ilas_done),
    .ilas_error               (ilas_error)
  );

  // Scoreboard consumer: every config strobe must match the oldest expected beat.
  always @(negedge clk) begin
    logic [33:0] e;
    if (!reset && ilas_config_valid) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL cfg_strobe_unexpected: got addr=%0d data=%h, none expected",
                 ilas_config_addr, ilas_config_data);
      end else begin
        e = exp_q.pop_front();
        if ({ilas_config_addr, ilas_config_data} !== e) begin
          n_miss++;
          $display("FAIL cfg_strobe: got addr=%0d data=%h, want addr=%0d data=%h",
                   ilas_config_addr, ilas_config_data, e[33:32], e[31:0]);
        end
      end
    end
  end

  task automatic idle_beats(input int n, input int err_at);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      n_vec++;
      if (ilas_error !== 1'b0 || ilas_done !== 1'b0) begin
        n_miss++;
        $display("FAIL idle_status: got err=%b done=%b, want err=0 done=0", ilas_error, ilas_done);
      end
      data          = 32'hBCBC_BCBC;
      charisk       = 4'hF;
      char_is_error = (i == err_at) ? 4'b0010 : 4'b0000;
    end
  endtask

  task automatic drop_cgs();
    @(negedge clk);
    data = 32'hBCBC_BCBC; charisk = 4'hF; char_is_error = 4'b0000;
    cgs_ready = 1'b0;
    @(negedge clk);
    cgs_ready = 1'b1;
    n_vec++;
    if (ilas_error !== 1'b0 || ilas_done !== 1'b0 || ilas_config_valid !== 1'b0) begin
      n_miss++;
      $display("FAIL cgs_drop_clear: got err=%b done=%b valid=%b, want all 0",
               ilas_error, ilas_done, ilas_config_valid);
    end
  endtask

  // bad_kind: 0 none, 1 missing /Q/, 2 /A/ without K at bad_beat, 3 char error at bad_beat.
  // abort_kind: 0 none, 1 cgs_ready drop at abort_beat, 2 async reset at abort_beat.
  task automatic send_ilas(input int cfgb, input int bad_kind, input int bad_beat,
                           input int abort_kind, input int abort_beat);
    int bpm, total, mf, bt;
    logic [31:0] w;
    logic [3:0]  k, e;
    bit exp_err, exp_done, fail;
    bpm = cfgb + 1;
    total = NUM_MF * bpm;
    cfg_bpm = 8'(cfgb);
    exp_err = 1'b0;
    exp_done = 1'b0;
    for (int b = 0; b < total; b++) begin
      mf = b / bpm;
      bt = b % bpm;
      @(negedge clk);
      n_vec++;
      if (ilas_error !== exp_err || ilas_done !== exp_done) begin
        n_miss++;
        $display("FAIL ilas_status beat %0d: got err=%b done=%b, want err=%b done=%b",
                 b, ilas_error, ilas_done, exp_err, exp_done);
      end
      if (abort_kind != 0 && b == abort_beat) begin
        data = 32'hBCBC_BCBC; charisk = 4'hF; char_is_error = 4'b0000;
        if (abort_kind == 1) begin
          cgs_ready = 1'b0;
          @(negedge clk);
          cgs_ready = 1'b1;
          n_vec++;
          if (ilas_error !== 1'b0 || ilas_done !== 1'b0 || ilas_config_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL cgs_loss: got err=%b done=%b valid=%b, want all 0",
                     ilas_error, ilas_done, ilas_config_valid);
          end
        end else begin
          #2 reset = 1'b1;
          #1;
          n_vec++;
          if ({ilas_config_valid, ilas_config_addr, ilas_config_data, ilas_done, ilas_error} !== 37'd0) begin
            n_miss++;
            $display("FAIL async_reset_ilas: got valid=%b addr=%0d data=%h done=%b err=%b, want all 0",
                     ilas_config_valid, ilas_config_addr, ilas_config_data, ilas_done, ilas_error);
          end
          @(negedge clk);
          reset = 1'b0;
        end
        return;
      end
      w = $urandom;
      k = 4'b0000;
      e = 4'b0000;
      if (mf == 1 && bt < 4) w = cfg_words[bt];
      if (bt == 0) begin w[7:0] = 8'h1C; k[0] = 1'b1; end
      if (mf == 1 && bt == 0) begin w[15:8] = 8'h9C; k[1] = 1'b1; end
      if (bt == cfgb) begin w[31:24] = 8'h7C; k[3] = 1'b1; end
      fail = 1'b0;
      if (bad_kind == 1 && b == bpm) begin w[15:8] = 8'hBC; fail = 1'b1; end
      if (bad_kind == 2 && b == bad_beat) begin k[3] = 1'b0; fail = 1'b1; end
      if (bad_kind == 3 && b == bad_beat) begin e = 4'b0100; fail = 1'b1; end
      data = w; charisk = k; char_is_error = e;
      if (mf == 1 && bt < 4 && !exp_err) exp_q.push_back({2'(bt), w});
      if (fail) exp_err = 1'b1;
      else if (b == total - 1 && !exp_err) exp_done = 1'b1;
    end
    @(negedge clk);
    data = 32'hBCBC_BCBC; charisk = 4'hF; char_is_error = 4'b0000;
    n_vec++;
    if (ilas_error !== exp_err || ilas_done !== exp_done) begin
      n_miss++;
      $display("FAIL ilas_final: got err=%b done=%b, want err=%b done=%b",
               ilas_error, ilas_done, exp_err, exp_done);
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL cfg_strobe_missing: got %0d outstanding, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cgs_ready = 1'b0; cfg_bpm = 8'd7;
    data = 32'd0; charisk = 4'd0; char_is_error = 4'd0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({ilas_config_valid, ilas_config_addr, ilas_config_data, ilas_done, ilas_error} !== 37'd0) begin
      n_miss++;
      $display("FAIL reset_state: got valid=%b addr=%0d data=%h done=%b err=%b, want all 0",
               ilas_config_valid, ilas_config_addr, ilas_config_data, ilas_done, ilas_error);
    end
    reset = 1'b0;
  endtask

  task automatic test_nominal();
    cgs_ready = 1'b1;
    idle_beats(10, -1);
    send_ilas(7, 0, 0, 0, 0);
  endtask

  task automatic test_reset_in_done();
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if ({ilas_config_valid, ilas_done, ilas_error} !== 3'b000) begin
      n_miss++;
      $display("FAIL async_reset_done: got valid=%b done=%b err=%b, want all 0",
               ilas_config_valid, ilas_done, ilas_error);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_missing_q();
    idle_beats(3, -1);
    send_ilas(7, 1, 0, 0, 0);
  endtask

  task automatic test_missing_a();
    drop_cgs();
    idle_beats(3, -1);
    send_ilas(7, 2, 15, 0, 0);
    drop_cgs();
    idle_beats(3, -1);
    send_ilas(7, 0, 0, 0, 0);
  endtask

  task automatic test_char_error();
    drop_cgs();
    idle_beats(4, 1);
    send_ilas(7, 3, 20, 0, 0);
  endtask

  task automatic test_cgs_loss();
    drop_cgs();
    idle_beats(3, -1);
    send_ilas(7, 0, 0, 1, 10);
    idle_beats(3, -1);
    send_ilas(7, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid_ilas();
    drop_cgs();
    idle_beats(3, -1);
    send_ilas(7, 0, 0, 2, 10);
    idle_beats(3, -1);
    send_ilas(7, 0, 0, 0, 0);
  endtask

  task automatic test_short_multiframe();
    drop_cgs();
    idle_beats(3, -1);
    send_ilas(3, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_reset_in_done();
    test_missing_q();
    test_missing_a();
    test_char_error();
    test_cgs_loss();
    test_reset_mid_ilas();
    test_short_multiframe();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/jesd204_rx_ilas_check.md
Name: jesd204_rx_ilas_check

Overview:
- Per-lane receive stage directly downstream of jesd204_rx_cgs.
- Once CGS reports ready, it tracks the Initial Lane Alignment Sequence (ILAS) on the 4-octet-per-beat lane stream and checks the /R/, /Q/ and /A/ control characters.
- It extracts the 14 ILAS configuration octets and flags the end of ILAS, so the lane buffer can start accepting user data.

Parameters:
- NUM_MULTIFRAMES, 4, number of ILAS multiframes expected (legal range 2..8).

Ports:
- clk  in  1  lane/device clock
- reset  in  1  asynchronous, active-high reset
- cgs_ready  in  1  ready output of jesd204_rx_cgs for this lane
- cfg_beats_per_multiframe  in  8  beats per multiframe minus 1; static while cgs_ready=1; legal range 3..255
- data  in  32  decoded octets; octet 0 = data[7:0] is first in time
- charisk  in  4  per-octet K-character flag
- char_is_error  in  4  per-octet disparity/not-in-table error
- ilas_config_valid  out  1  config beat strobe
- ilas_config_addr  out  2  config beat index 0..3
- ilas_config_data  out  32  config beat (raw data of multiframe 1, beats 0..3)
- ilas_done  out  1  ILAS completed correctly; level signal
- ilas_error  out  1  ILAS violation detected; level signal

Behaviour:
- Characters checked:
  - /R/ = 0x1C with K set.
  - /Q/ = 0x9C with K set.
  - /A/ = 0x7C with K set.
- Reset and cgs_ready=0 state:
  - On reset, all outputs are 0 and the state is IDLE.
  - cgs_ready=0 in any state forces IDLE on the next edge, clears ilas_done/ilas_error/ilas_config_valid and clears the counters.
- States:
  - IDLE: wait for cgs_ready=1, then go to WAIT_R.
  - WAIT_R: the first beat with data[7:0]=/R/ and charisk[0]=1 is beat 0 of multiframe 0; go to ILAS. Beats without /R/ (trailing /K/) are ignored.
  - ILAS: the beat counter (8 bit) and multiframe counter (3 bit) advance every cycle. At beat == cfg_beats_per_multiframe, the beat counter wraps to 0 and the multiframe counter increments.
  - DONE: ilas_done=1. Held until cgs_ready drops.
  - ERROR: ilas_error=1. Held until cgs_ready drops. No automatic retry.
- Checks in ILAS (any failure moves to ERROR at the next edge):
  - Beat 0 of every multiframe: octet 0 is /R/. This includes the WAIT_R entry beat, which is already qualified.
  - Last beat of every multiframe: octet 3 is /A/.
  - Multiframe 1, beat 0: octet 1 is /Q/.
  - Any char_is_error bit set on any beat processed in ILAS, including the /R/ entry beat.
  - /R/ or /A/ in any other octet position of the ILAS is not checked.
- Completion:
  - On the last beat of multiframe NUM_MULTIFRAMES-1 with all checks passing, go to DONE.
  - ilas_done rises exactly 1 cycle after that beat.
  - If that final beat also fails a check, ERROR wins.
- Config capture:
  - For multiframe 1, beats 0..3, register data onto ilas_config_data with ilas_config_addr = beat index and ilas_config_valid=1.
  - Latency is 1 cycle after the beat; one strobe per beat; 4 strobes total.
  - The strobe is still emitted for the beat whose check fails; no strobes after entering ERROR.
- Timing:
  - ILAS length is NUM_MULTIFRAMES*(cfg_beats_per_multiframe+1) beats.
  - Out-of-range cfg_beats_per_multiframe (<3) gives undefined results. This is not checked.
- Simultaneous events: a cgs_ready fall has priority over all checks and over completion.

Test Plan:
- Nominal ILAS:
  - Stimulus: cfg=7, NUM_MULTIFRAMES=4, 10 /K/ beats then a correct 32-beat ILAS with config beats 0x0201_9C1C, 0x0605_0403, 0x0A09_0807, 0x0E0D_0C0B.
  - Required response: 4 config strobes, addr 0..3 with exactly those values, each 1 cycle after its beat. ilas_done=1 one cycle after beat 31; ilas_error stays 0.
- Missing /Q/:
  - Stimulus: multiframe 1 beat 0 octet 1 = 0xBC with K set.
  - Required response: ilas_error=1 one cycle later; the addr-0 strobe still occurs; no further strobes; ilas_done never asserts.
- Missing /A/:
  - Stimulus: octet 3 of beat 15 (end of multiframe 1) = 0x7C with charisk[3]=0.
  - Required response: ilas_error=1 at the next cycle, held. Then drop cgs_ready for 1 cycle and send a correct ILAS: error clears and ilas_done=1.
- Character error:
  - Stimulus: char_is_error=4'b0100 on beat 20.
  - Required response: ilas_error=1 at the next cycle.
  - Also: char_is_error=4'b0010 while in WAIT_R produces no error.
- CGS loss:
  - Stimulus: cgs_ready=0 at beat 10 of the ILAS, then restored.
  - Required response: no error or done; the block restarts at the next /R/ and completes normally.
- Asynchronous reset:
  - Stimulus: reset asserted mid-clock during ILAS, and separately while in DONE.
  - Required response: all outputs 0 immediately, without waiting for a clock edge.
